i2c_master_byte_seq: RTL
========================

# i2c_master_byte_seq

Byte-level sequencer sitting between the host register interface and the I2C bit controller. Turns one host byte command (optional START, WRITE or READ of 8 bits, ACK bit, optional STOP) into a series of single-bit commands to the bit controller. Shifts data MSB-first, collects the slave ACK or drives the master ACK, and returns one completion pulse per host command.

## Interface
Parameters:
- None. Byte width is fixed at 8.

Ports:
- `clk` in 1: system clock. One clock domain; all logic is on its rising edge.
- `rst` in 1: reset. Synchronous and active-high.
- `start` in 1: generate START before the data phase.
- `stop` in 1: generate STOP after the ACK phase.
- `read` in 1: read one byte.
- `write` in 1: write one byte.
- `ack_in` in 1: ACK value the master drives after a read (0 = ACK, 1 = NACK).
- `din` in 8: byte to write.
- `cmd_ack` out 1: one-cycle pulse when the host command has completed or been aborted.
- `ack_out` out 1: ACK bit sampled from the slave after a write (0 = ACK).
- `dout` out 8: received byte. Valid from the `cmd_ack` cycle until the next command.
- `al_o` out 1: one-cycle pulse when arbitration is lost.
- `core_cmd` out 4: bit-controller command. NOP=0000, START=0001, STOP=0010, WRITE=0100, READ=1000.
- `core_txd` out 1: bit value for a WRITE bit command.
- `core_ack` in 1: bit-controller command-complete pulse.
- `core_rxd` in 1: bit value sampled by the bit controller.
- `core_al` in 1: bit-controller arbitration-lost flag.

## Operation
- Host request lines are levels. The host holds them until `cmd_ack` and drops them in the following cycle. `go` = `start | stop | read | write`.
- States are IDLE, START, WRITE, READ, ACK, STOP.
- 3-bit down-counter `cnt` and 8-bit shift register `sr`.
- **IDLE**, on `go` and `!core_al`:
  - Always: `sr` <= `din`, `cnt` <= 7.
  - If `start`: go to START, `core_cmd` = START.
  - Else if `read`: go to READ, `core_cmd` = READ.
  - Else if `write`: go to WRITE, `core_cmd` = WRITE.
  - Else (stop only): go to STOP, `core_cmd` = STOP.
  - Priority when several are set: start > read > write > stop. `read` wins over `write` if both are set.
- **START**, on `core_ack`: go to READ or WRITE with the matching `core_cmd`. If neither `read` nor `write` is set, go to STOP if `stop`, otherwise go to IDLE with `cmd_ack`.
- **WRITE / READ**, on `core_ack`:
  - `sr` <= {`sr[6:0]`, `core_rxd`}.
  - If `cnt` == 0: go to ACK. `core_cmd` = READ after a write phase; `core_cmd` = WRITE after a read phase.
  - Else: `cnt` <= `cnt` - 1, `core_cmd` unchanged.
- `core_txd` = `sr[7]` in WRITE, `ack_in` in ACK after a read, 0 otherwise.
- **ACK**, on `core_ack`:
  - `ack_out` <= `core_rxd`; `dout` <= `sr`.
  - If `stop`: go to STOP, `core_cmd` = STOP.
  - Else: go to IDLE, `core_cmd` = NOP, `cmd_ack` = 1.
- **STOP**, on `core_ack`: go to IDLE, `core_cmd` = NOP, `cmd_ack` = 1.
- **Arbitration lost.** `core_al` high in any non-IDLE state:
  - Next cycle: IDLE, `core_cmd` = NOP, `cmd_ack` = 1, `al_o` = 1.
  - `dout` and `ack_out` are unchanged.
  - IDLE does not accept a new command while `core_al` is high.
- `core_ack` in IDLE is ignored.

## Timing
- All outputs are registered.
- Reset values: `core_cmd` = 0000, `core_txd` = 0, `cmd_ack` = 0, `ack_out` = 0, `dout` = 00, `al_o` = 0, state = IDLE, `cnt` = 0, `sr` = 00.
- `rst` mid-transfer: the next edge forces every reset value. No STOP is generated.
- Request to first `core_cmd`: 1 cycle.
- `core_ack` to updated `core_cmd` / `core_txd`: 1 cycle. The bit controller's prescale must be ≥ 1 so the old command is never re-sampled.
- `cmd_ack` is high exactly 1 cycle after the `core_ack` of the last bit command (ACK or STOP) and is never high on two consecutive cycles.
- The command is ignored in the cycle after `cmd_ack`, so the host has one cycle to drop its request lines.
- Bit commands per host command: 9 for a plain read or write, +1 for START, +1 for STOP.

## Configuration
- Macro `I2C_BYTE_SEQ_NACK_STOP_EN`.
- Defined: on ACK completion after a write, if `core_rxd` = 1 (NACK) and `stop` = 0, the sequencer goes to STOP automatically instead of IDLE. `cmd_ack` fires after the STOP completes, with `ack_out` = 1.
- Undefined: a NACK is only reported in `ack_out`; no automatic STOP.

## Test plan
- START+WRITE `din` = A5, slave ACKs: `core_cmd` sequence is START, WRITE ×8 with `core_txd` = 1,0,1,0,0,1,0,1, then READ. `cmd_ack` pulses once with `ack_out` = 0.
- READ+STOP, `ack_in` = 1, slave returns 3C: READ ×8, WRITE with `core_txd` = 1, then STOP. `cmd_ack` pulses after STOP with `dout` = 3C.
- WRITE 00, slave NACKs, `stop` = 0:
  - Macro undefined: `cmd_ack` with `ack_out` = 1 and `core_cmd` = NOP.
  - Macro defined: STOP is issued before `cmd_ack`.
- `core_al` asserted during bit 4 of a write: the next cycle shows IDLE, `core_cmd` = 0000, with `cmd_ack` and `al_o` pulsing together. `dout` is unchanged.
- `rst` asserted during READ bit 2: the next cycle shows all reset values. A following WRITE 5A completes normally.
- STOP only: `core_cmd` = STOP immediately, and `cmd_ack` pulses 1 cycle after `core_ack`.

Source files
------------

// File: rtl/i2c_master_byte_seq.sv
// Byte sequencer: one host byte command becomes START/8 data bits/ACK/STOP bit commands for the I2C bit controller.
// Latency: 1 cycle from request or core_ack to the next core_cmd. Optional build macro: I2C_BYTE_SEQ_NACK_STOP_EN (auto STOP on write NACK).
module i2c_master_byte_seq (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       read,
    input  logic       write,
    input  logic       ack_in,
    input  logic [7:0] din,
    output logic       cmd_ack,
    output logic       ack_out,
    output logic [7:0] dout,
    output logic       al_o,
    output logic [3:0] core_cmd,
    output logic       core_txd,
    input  logic       core_ack,
    input  logic       core_rxd,
    input  logic       core_al
);

    localparam logic [3:0] CMD_NOP   = 4'b0000;
    localparam logic [3:0] CMD_START = 4'b0001;
    localparam logic [3:0] CMD_STOP  = 4'b0010;
    localparam logic [3:0] CMD_WRITE = 4'b0100;
    localparam logic [3:0] CMD_READ  = 4'b1000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_WRITE,
        ST_READ,
        ST_ACK,
        ST_STOP
    } state_t;

    state_t     state;
    logic [2:0] cnt;
    logic [7:0] sr;
    logic       rd_phase;
    logic       go;
    logic       nack_stop;

    assign go = start | stop | read | write;

`ifdef I2C_BYTE_SEQ_NACK_STOP_EN
    assign nack_stop = !rd_phase && core_rxd;
`else
    assign nack_stop = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= 3'd0;
            sr       <= 8'h00;
            rd_phase <= 1'b0;
            core_cmd <= CMD_NOP;
            core_txd <= 1'b0;
            cmd_ack  <= 1'b0;
            ack_out  <= 1'b0;
            dout     <= 8'h00;
            al_o     <= 1'b0;
        end else begin
            cmd_ack <= 1'b0;
            al_o    <= 1'b0;
            if (state != ST_IDLE && core_al) begin
                state    <= ST_IDLE;
                core_cmd <= CMD_NOP;
                core_txd <= 1'b0;
                cmd_ack  <= 1'b1;
                al_o     <= 1'b1;
            end else begin
                case (state)
                    // cmd_ack still high means the host has not yet dropped the finished request
                    ST_IDLE: begin
                        if (go && !core_al && !cmd_ack) begin
                            sr       <= din;
                            cnt      <= 3'd7;
                            rd_phase <= read;
                            if (start) begin
                                state    <= ST_START;
                                core_cmd <= CMD_START;
                                core_txd <= 1'b0;
                            end else if (read) begin
                                state    <= ST_READ;
                                core_cmd <= CMD_READ;
                                core_txd <= 1'b0;
                            end else if (write) begin
                                state    <= ST_WRITE;
                                core_cmd <= CMD_WRITE;
                                core_txd <= din[7];
                            end else begin
                                state    <= ST_STOP;
                                core_cmd <= CMD_STOP;
                                core_txd <= 1'b0;
                            end
                        end
                    end
                    ST_START: begin
                        if (core_ack) begin
                            if (read) begin
                                state    <= ST_READ;
                                core_cmd <= CMD_READ;
                                core_txd <= 1'b0;
                            end else if (write) begin
                                state    <= ST_WRITE;
                                core_cmd <= CMD_WRITE;
                                core_txd <= sr[7];
                            end else if (stop) begin
                                state    <= ST_STOP;
                                core_cmd <= CMD_STOP;
                                core_txd <= 1'b0;
                            end else begin
                                state    <= ST_IDLE;
                                core_cmd <= CMD_NOP;
                                core_txd <= 1'b0;
                                cmd_ack  <= 1'b1;
                            end
                        end
                    end
                    ST_WRITE, ST_READ: begin
                        if (core_ack) begin
                            sr <= {sr[6:0], core_rxd};
                            if (cnt == 3'd0) begin
                                state <= ST_ACK;
                                if (state == ST_WRITE) begin
                                    core_cmd <= CMD_READ;
                                    core_txd <= 1'b0;
                                end else begin
                                    core_cmd <= CMD_WRITE;
                                    core_txd <= ack_in;
                                end
                            end else begin
                                cnt      <= cnt - 3'd1;
                                core_txd <= (state == ST_WRITE) ? sr[6] : 1'b0;
                            end
                        end
                    end
                    ST_ACK: begin
                        if (core_ack) begin
                            ack_out  <= core_rxd;
                            dout     <= sr;
                            core_txd <= 1'b0;
                            if (stop || nack_stop) begin
                                state    <= ST_STOP;
                                core_cmd <= CMD_STOP;
                            end else begin
                                state    <= ST_IDLE;
                                core_cmd <= CMD_NOP;
                                cmd_ack  <= 1'b1;
                            end
                        end
                    end
                    ST_STOP: begin
                        if (core_ack) begin
                            state    <= ST_IDLE;
                            core_cmd <= CMD_NOP;
                            core_txd <= 1'b0;
                            cmd_ack  <= 1'b1;
                        end
                    end
                    default: begin
                        state    <= ST_IDLE;
                        core_cmd <= CMD_NOP;
                        core_txd <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
